// File: rtl/addsub_pkg.sv
// Shared types and constants for the sequential chunked adder/subtractor.
// Holds the FSM state type, mode encodings and the WIDTH/CHUNK legality check.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Legal only when WIDTH splits into a whole number of CHUNK-bit slices.
    function automatic bit cfg_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry slice; also exposes the carry into
// its top bit so the parent can derive signed overflow on the last slice.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic carry;

    // NOTE: blocking assignments are correct here; 'carry' is a combinational
    // temporary that must ripple bit-to-bit within a single evaluation.
    always_comb begin
        carry    = cin;
        sum      = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb_in = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
        cout = carry;
    end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement add/sub: one CHUNK-bit slice per clock with a
// registered ripple carry, valid/ready handshake, accumulate mode and flags.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    input  logic             acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             v,
    output logic             z,
    output logic             n
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
        $error("addsub_seq: WIDTH must be a positive multiple of CHUNK");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opb_q, res_q, res_d;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               c_out_q, v_q, z_q, n_q;

    logic [CHUNK-1:0]   slice_a, slice_b, slice_sum;
    logic               slice_cout, slice_c_msb;
    logic               last_slice;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // ---------------- Slice datapath ----------------
    assign last_slice = (idx_q == IDX_W'(NCH - 1));
    assign slice_a    = opa_q[idx_q*CHUNK +: CHUNK];
    assign slice_b    = opb_q[idx_q*CHUNK +: CHUNK];

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (slice_a),
        .b        (slice_b),
        .cin      (carry_q),
        .sum      (slice_sum),
        .cout     (slice_cout),
        .c_msb_in (slice_c_msb)
    );

    always_comb begin
        res_d                        = res_q;
        res_d[idx_q*CHUNK +: CHUNK]  = slice_sum;
    end

    // NOTE: the result register and flags are reset (not left to power-up
    // state) because an abandoned operation must present s=0 and clear flags,
    // and the first accumulate after reset must start from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        opa_q   <= acc ? res_q : a;
                        opb_q   <= (m == MODE_SUB) ? ~b : b;
                        carry_q <= (m == MODE_SUB);
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (last_slice) begin
                        c_out_q <= slice_cout;
                        v_q     <= slice_c_msb ^ slice_cout;
                        z_q     <= (res_d == '0);
                        n_q     <= res_d[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign s     = res_q;
    assign c_out = c_out_q;
    assign v     = v_q;
    assign z     = z_q;
    assign n     = n_q;

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised multi-cycle two's-complement adder/subtractor for the datapath. Processes a WIDTH-bit operation in CHUNK-bit slices per clock with an internal ripple carry between slices. Adds a valid/ready handshake, an accumulate mode and registered status flags (carry, overflow, zero, negative). It sits between the operand-select logic and the result bus, and replaces the fixed 4-bit combinational add/sub stage.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; NCH = WIDTH/CHUNK slice cycles.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block accepts a request; high only in IDLE.
- a  input  WIDTH  operand A; ignored when acc=1.
- b  input  WIDTH  operand B.
- m  input  1  mode: 0 = A+B, 1 = A−B (B inverted, carry-in = 1).
- acc  input  1  accumulate: operand A = current result register.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes the result.
- s  output  WIDTH  result.
- c_out  output  1  carry out of MSB; for subtraction 1 = no borrow (A ≥ B unsigned).
- v  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- z  output  1  s == 0.
- n  output  1  s[WIDTH−1].

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid at a clock edge:
  - latch opA = (acc ? result register : a);
  - latch opB = b XOR {WIDTH{m}};
  - carry = m, slice index = 0;
  - go to RUN.
- RUN: each cycle, slice i computes opA[i] + opB[i] + carry.
  - The CHUNK sum bits are written into result slice i; carry is updated; index increments.
  - On the last slice (i = NCH−1), record the carry into the MSB and the carry out, then go to DONE.
- DONE: out_valid=1. Outputs s, c_out, v, z, n are held stable until out_ready=1, then go to IDLE.
- No request is accepted in RUN or DONE.
- in_valid during DONE together with out_ready is not accepted that cycle; it is accepted in the following IDLE cycle.
- s is the result register itself and may change during RUN. It is meaningful only while out_valid=1.
- Flags are registered when the block enters DONE and do not change until the next DONE.
- The result register persists across operations; it feeds acc=1 requests.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0;
  - s = 0, c_out = 0, v = 0, z = 0, n = 0;
  - result register = 0.
- Latency: request accepted at edge E0; out_valid first high after edge E_NCH (4 cycles at the defaults).
- Throughput: one operation per NCH+2 cycles when out_ready is held high.
- Backpressure: out_valid, s and flags remain unchanged while out_ready=0.
- Reset during RUN or DONE: the operation is abandoned and every output returns to its reset value on the next edge.
- The first operation after reset with acc=1 uses A = 0.
- CHUNK = WIDTH is legal: NCH = 1, result after one RUN cycle.

## Structure
- Shared package addsub_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - mode constants MODE_ADD = 0, MODE_SUB = 1;
  - an elaboration-time check that WIDTH % CHUNK == 0.
- Sub-module addsub_chunk: combinational CHUNK-bit ripple slice.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, c_msb_in (carry into the slice's top bit).
  - Instantiated once and muxed by slice index.
- The top level holds the FSM, operand registers, index counter, carry register and flag logic.

## Test plan
- Add 0x1234 + 0x0FCD, m=0 → s=0x2201, c_out=0, v=0, z=0, n=0; out_valid exactly 4 cycles after acceptance.
- Subtract 0x8000 − 0x0001, m=1 → s=0x7FFF, c_out=1, v=1, n=0. Subtract 0x0005 − 0x0005 → s=0x0000, z=1, c_out=1, v=0.
- Add 0x7FFF + 0x0001 → s=0x8000, v=1, n=1, c_out=0. Add 0xFFFF + 0x0001 → s=0x0000, c_out=1, z=1, v=0.
- After reset, acc=1 add b=0x0003 three times → s = 0x0003, 0x0006, 0x0009. Then acc=1 subtract 0x000A → s=0xFFFF, c_out=0, n=1, v=0.
- Hold out_ready low for 3 cycles in DONE with in_valid high → s and flags stable, in_ready=0, no new acceptance. Raise out_ready → IDLE, then the next request is accepted.
- Assert rst for one cycle mid-RUN → next cycle IDLE, out_valid=0, s=0. A following 0x0001 + 0x0001 gives s=0x0002. Repeat the add tests with WIDTH=8, CHUNK=8 (1 RUN cycle).
